reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_pkg.sv | 13 +
 rtl/reg_wb_arbiter_rr_arb2.sv | 49 ++++
 rtl/reg_wb_arbiter.sv | 110 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared constants for the register write-back arbiter: default widths and
// requester indices used by the grant logic and its pointer.
package reg_wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and a
// one-bit pointer holding the most recently granted requester.
module rr_arb2
    import reg_wb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1
);

    req_idx_e last_r;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
            gnt0 = (last_r == REQ1);
            gnt1 = (last_r == REQ0);
        end else if (req0_valid) begin
            gnt0 = 1'b1;
        end else if (req1_valid) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Pointer records the last winner; reset value lets requester 0 win first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= REQ1;
        end else if (gnt0) begin
            last_r <= REQ0;
        end else if (gnt1) begin
            last_r <= REQ1;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: two requesters share one write port through
// a registered output stage. Define WB_FWD_EN to bypass write data to read ports.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [REG_AW-1:0] req0_addr,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_AW-1:0] req1_addr,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    output logic              we,
    output logic [REG_AW-1:0] waddr_rd,
    output logic [XLEN-1:0]   wdata_rd,
    input  logic [REG_AW-1:0] raddr_rs1,
    input  logic [REG_AW-1:0] raddr_rs2,
    input  logic [XLEN-1:0]   rf_rdata_rs1,
    input  logic [XLEN-1:0]   rf_rdata_rs2,
    output logic [XLEN-1:0]   rdata_rs1,
    output logic [XLEN-1:0]   rdata_rs2
);

    logic              gnt0_s;
    logic              gnt1_s;
    logic              xfer_s;
    logic [REG_AW-1:0] sel_addr_s;
    logic [XLEN-1:0]   sel_data_s;
    logic              we_r;
    logic [REG_AW-1:0] waddr_r;
    logic [XLEN-1:0]   wdata_r;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt0       (gnt0_s),
        .gnt1       (gnt1_s)
    );

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign xfer_s     = gnt0_s | gnt1_s;

    // Route the granted requester's address and data to the output stage.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (gnt1_s) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
    end

    // Output stage: x0 targets are accepted but never raise we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            waddr_r <= {REG_AW{1'b0}};
            wdata_r <= {XLEN{1'b0}};
        end else if (xfer_s) begin
            we_r    <= (sel_addr_s != {REG_AW{1'b0}});
            waddr_r <= sel_addr_s;
            wdata_r <= sel_data_s;
        end else begin
            we_r    <= 1'b0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    assign we       = we_r;
    assign waddr_rd = waddr_r;
    assign wdata_rd = wdata_r;

`ifdef WB_FWD_EN
    // Bypass the in-flight write to readers of the same non-zero register.
    always_comb begin
        rdata_rs1 = rf_rdata_rs1;
        rdata_rs2 = rf_rdata_rs2;
        if (we_r && (waddr_r == raddr_rs1) && (raddr_rs1 != {REG_AW{1'b0}})) begin
            rdata_rs1 = wdata_r;
        end else begin
            rdata_rs1 = rf_rdata_rs1;
        end
        if (we_r && (waddr_r == raddr_rs2) && (raddr_rs2 != {REG_AW{1'b0}})) begin
            rdata_rs2 = wdata_r;
        end else begin
            rdata_rs2 = rf_rdata_rs2;
        end
    end
`else
    // Read addresses go straight to the register file and are not needed here.
    logic unused_raddr_s;
    assign unused_raddr_s = ^{raddr_rs1, raddr_rs2};
    assign rdata_rs1      = rf_rdata_rs1;
    assign rdata_rs2      = rf_rdata_rs2;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_reg_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
    logic [XLEN-1:0] req0_data = '0, req1_data = '0;
    logic            req0_ready, req1_ready, we;
    logic [AW-1:0]   waddr_rd;
    logic [XLEN-1:0] wdata_rd;
    logic [AW-1:0]   raddr_rs1 = '0, raddr_rs2 = '0;
    logic [XLEN-1:0] rf_rdata_rs1, rf_rdata_rs2;
    logic [XLEN-1:0] rdata_rs1, rdata_rs2;

    int total = 0;
    int passed = 0;

    int              m_last = 1;
    logic            exp_we = 1'b0;
    logic [AW-1:0]   exp_waddr = '0;
    logic [XLEN-1:0] exp_wdata = '0;
    logic [XLEN-1:0] rf_exp [32] = '{default: '0};
    logic [XLEN-1:0] rf_mem [32] = '{default: '0};
    logic            use_mem = 1'b1;
    logic [XLEN-1:0] rf_force1 = '0, rf_force2 = '0;

    reg_wb_arbiter #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
        .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
        .rf_rdata_rs1(rf_rdata_rs1), .rf_rdata_rs2(rf_rdata_rs2),
        .rdata_rs1(rdata_rs1), .rdata_rs2(rdata_rs2)
    );

    always #5 clk = ~clk;

    // Behavioural register file fed by the DUT write port.
    always @(posedge clk) if (we) rf_mem[waddr_rd] <= wdata_rd;
    assign rf_rdata_rs1 = use_mem ? rf_mem[raddr_rs1] : rf_force1;
    assign rf_rdata_rs2 = use_mem ? rf_mem[raddr_rs2] : rf_force2;

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [XLEN-1:0] model_rdata(input logic [AW-1:0] ra, input logic [XLEN-1:0] raw);
`ifdef WB_FWD_EN
        if (exp_we && exp_waddr == ra && ra != 0) return exp_wdata;
`endif
        return raw;
    endfunction

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
    endtask

    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (!rst_n) begin
            exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; m_last = 1;
        end else if (g == 0) begin
            exp_we = (req0_addr != 0); exp_waddr = req0_addr; exp_wdata = req0_data; m_last = 0;
        end else if (g == 1) begin
            exp_we = (req1_addr != 0); exp_waddr = req1_addr; exp_wdata = req1_data; m_last = 1;
        end else begin
            exp_we = 1'b0;
        end
        if (exp_we) rf_exp[exp_waddr] = exp_wdata;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        else passed++;
        tick(); tick();
        total++;
        if (we !== 1'b0 || waddr_rd !== 5'd0 || wdata_rd !== 32'd0)
            $display("FAIL reset_out: got we=%b wa=%h wd=%h expected 0/0/0", we, waddr_rd, wdata_rd);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
        else passed++;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        total++;
        if (we !== 1'b1 || waddr_rd !== 5'd5 || wdata_rd !== 32'hDEADBEEF)
            $display("FAIL single_write: got we=%b wa=%h wd=%h expected 1/05/deadbeef", we, waddr_rd, wdata_rd);
        else passed++;
        tick();
        total++;
        if (we !== 1'b0 || waddr_rd !== 5'd5 || wdata_rd !== 32'hDEADBEEF)
            $display("FAIL idle_hold: got we=%b wa=%h wd=%h expected 0/05/deadbeef", we, waddr_rd, wdata_rd);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] ea;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200);
            total++;
            if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1))
                $display("FAIL rr_grant%0d: got %b%b expected requester %0d", i, req0_ready, req1_ready, i % 2);
            else passed++;
            tick();
            ea = ((i % 2) == 0) ? 5'd1 : 5'd2;
            total++;
            if (we !== 1'b1 || waddr_rd !== ea)
                $display("FAIL rr_write%0d: got we=%b wa=%h expected 1/%h", i, we, waddr_rd, ea);
            else passed++;
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_x0_drop();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
            $display("FAIL x0_ready: got %b%b expected 01", req0_ready, req1_ready);
        else passed++;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        total++;
        if (we !== 1'b0)
            $display("FAIL x0_we: got %b expected 0", we);
        else passed++;
        tick();
    endtask

    task automatic test_forward();
        logic [XLEN-1:0] e1, e2;
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        use_mem = 1'b0; rf_force1 = 32'd0; rf_force2 = 32'h55;
        raddr_rs1 = 5'd7; raddr_rs2 = 5'd0;
        #1;
`ifdef WB_FWD_EN
        e1 = 32'hA5A5A5A5;
`else
        e1 = 32'd0;
`endif
        e2 = 32'h55;
        total++;
        if (rdata_rs1 !== e1)
            $display("FAIL fwd_rs1: got %h expected %h", rdata_rs1, e1);
        else passed++;
        total++;
        if (rdata_rs2 !== e2)
            $display("FAIL fwd_rs2_x0: got %h expected %h", rdata_rs2, e2);
        else passed++;
        tick();
        use_mem = 1'b1;
    endtask

    task automatic test_same_reg();
        do_reset();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL same_first: got %b%b expected 10", req0_ready, req1_ready);
        else passed++;
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h22);
        total++;
        if (we !== 1'b1 || wdata_rd !== 32'h11 || req1_ready !== 1'b1)
            $display("FAIL same_w1: got we=%b wd=%h r1=%b expected 1/11/1", we, wdata_rd, req1_ready);
        else passed++;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        total++;
        if (we !== 1'b1 || wdata_rd !== 32'h22)
            $display("FAIL same_w2: got we=%b wd=%h expected 1/22", we, wdata_rd);
        else passed++;
        tick();
        raddr_rs1 = 5'd3;
        #1;
        total++;
        if (rdata_rs1 !== 32'h22)
            $display("FAIL same_read: got %h expected 00000022", rdata_rs1);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd9, 32'hCAFE, 1'b0, '0, '0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL mid_ready: got %b%b expected 00", req0_ready, req1_ready);
        else passed++;
        tick();
        total++;
        if (we !== 1'b0)
            $display("FAIL mid_we: got %b expected 0", we);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL mid_first: got %b%b expected 10", req0_ready, req1_ready);
        else passed++;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        logic            p0, p1;
        logic [AW-1:0]   a0, a1;
        logic [XLEN-1:0] d0, d1;
        int g;
        int errs;
        p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1'b1; a0 = AW'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 9) < 6) begin
                p1 = 1'b1; a1 = AW'($urandom_range(0, 31)); d1 = $urandom;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            raddr_rs1 = AW'($urandom_range(0, 31));
            raddr_rs2 = AW'($urandom_range(0, 31));
            drive(p0, a0, d0, p1, a1, d1);
            g = model_grant();
            total++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1))
                $display("FAIL rand_grant@%0d: got %b%b expected grant %0d", i, req0_ready, req1_ready, g);
            else passed++;
            total++;
            if (rdata_rs1 !== model_rdata(raddr_rs1, rf_mem[raddr_rs1]) ||
                rdata_rs2 !== model_rdata(raddr_rs2, rf_mem[raddr_rs2]))
                $display("FAIL rand_rdata@%0d: got %h/%h expected %h/%h", i, rdata_rs1, rdata_rs2,
                         model_rdata(raddr_rs1, rf_mem[raddr_rs1]), model_rdata(raddr_rs2, rf_mem[raddr_rs2]));
            else passed++;
            tick();
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
            total++;
            if (we !== exp_we || waddr_rd !== exp_waddr || wdata_rd !== exp_wdata)
                $display("FAIL rand_out@%0d: got we=%b wa=%h wd=%h expected %b/%h/%h",
                         i, we, waddr_rd, wdata_rd, exp_we, exp_waddr, exp_wdata);
            else passed++;
        end
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        tick();
        errs = 0;
        for (int r = 0; r < 32; r++) if (rf_mem[r] !== rf_exp[r]) errs++;
        total++;
        if (errs != 0)
            $display("FAIL rand_regfile: got %0d differing registers expected 0", errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_forward();
        test_round_robin();
        test_x0_drop();
        test_same_reg();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
